// File: rtl/fp_mul_operand_loader.sv
// fp_mul_operand_loader: assembles two byte-serial binary64 operands (A then B,
// LSB first) and hands them to the multiplier core over a valid/ready handshake.
// A partial frame that stalls for IDLE_TIMEOUT cycles is discarded.
// Optional feature macro: FP_CLASSIFY_EN (pre-resolves IEEE special products;
// assumes WORD_W = 64). Without it OP_SPECIAL/OP_SPECIAL_Z are tied to 0.
module fp_mul_operand_loader #(
  parameter int BYTE_W       = 8,
  parameter int WORD_W       = 64,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic [BYTE_W-1:0] DATA_IN,
  output logic              BUSY,
  output logic              OP_VALID,
  input  logic              OP_READY,
  output logic [WORD_W-1:0] OP_A,
  output logic [WORD_W-1:0] OP_B,
  output logic              OP_SPECIAL,
  output logic [WORD_W-1:0] OP_SPECIAL_Z,
  output logic              OVERRUN,
  output logic              FRAME_ABORT
);

  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    COLLECT_A = 2'd0,
    COLLECT_B = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [IDLE_W-1:0]   idle_reg, idle_next;
  logic                abort_reg, abort_next;
  logic                overrun_reg, overrun_set;
  logic                wr_a, wr_b;
  logic [WORD_W-1:0]   op_a_reg, op_b_reg;
  logic [NBYTES-1:0]   lane_sel;

  // One-hot byte-lane select decoded from the current byte count.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign lane_sel[gi] = (count_reg == CNT_W'(gi));
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= COLLECT_A;
    else       state_reg <= state_next;
  end

  // Next-state logic: byte counting, idle timeout, handshake and overrun detection.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    idle_next   = idle_reg;
    abort_next  = 1'b0;
    overrun_set = 1'b0;
    wr_a        = 1'b0;
    wr_b        = 1'b0;
    case (state_reg)
      COLLECT_A: begin
        if (ENABLE) begin
          wr_a      = 1'b1;
          idle_next = '0;
          if (count_reg == LAST_BYTE) begin
            count_next = '0;
            state_next = COLLECT_B;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end else if (count_reg != '0) begin
          // An empty A never times out; only a started frame can stall.
          if (idle_reg == IDLE_LAST) begin
            abort_next = 1'b1;
            count_next = '0;
            idle_next  = '0;
            state_next = COLLECT_A;
          end else begin
            idle_next = idle_reg + 1'b1;
          end
        end
      end
      COLLECT_B: begin
        if (ENABLE) begin
          wr_b      = 1'b1;
          idle_next = '0;
          if (count_reg == LAST_BYTE) begin
            count_next = '0;
            state_next = HOLD;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end else if (idle_reg == IDLE_LAST) begin
          abort_next = 1'b1;
          count_next = '0;
          idle_next  = '0;
          state_next = COLLECT_A;
        end else begin
          idle_next = idle_reg + 1'b1;
        end
      end
      HOLD: begin
        idle_next = '0;
        if (OP_READY) begin
          state_next = COLLECT_A;
          count_next = '0;
          // Zero-bubble: a byte on the accept edge is byte 0 of the next A.
          if (ENABLE) begin
            wr_a       = 1'b1;
            count_next = CNT_W'(1);
          end
        end else if (ENABLE) begin
          overrun_set = 1'b1;
        end
      end
      default: begin
        state_next = COLLECT_A;
        count_next = '0;
        idle_next  = '0;
      end
    endcase
  end

  // Counters, abort pulse and sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_reg   <= '0;
      idle_reg    <= '0;
      abort_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      idle_reg    <= idle_next;
      abort_reg   <= abort_next;
      overrun_reg <= overrun_reg | overrun_set;
    end
  end

  // Operand assembly: each accepted byte lands in the lane picked by the count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_a_reg <= '0;
      op_b_reg <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_a && lane_sel[i]) op_a_reg[i*BYTE_W +: BYTE_W] <= DATA_IN;
        if (wr_b && lane_sel[i]) op_b_reg[i*BYTE_W +: BYTE_W] <= DATA_IN;
      end
    end
  end

  assign OP_VALID    = (state_reg == HOLD);
  assign BUSY        = (state_reg == HOLD);
  assign OP_A        = op_a_reg;
  assign OP_B        = op_b_reg;
  assign OVERRUN     = overrun_reg;
  assign FRAME_ABORT = abort_reg;

`ifdef FP_CLASSIFY_EN
  // B as it will look after the final byte lands; lets the result register
  // on the same edge that enters HOLD.
  logic [WORD_W-1:0] b_full;
  logic              hold_load, hold_accept;
  logic              special_next, special_reg;
  logic [WORD_W-1:0] special_z_next, special_z_reg;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_z;

  assign b_full      = {DATA_IN, op_b_reg[WORD_W-BYTE_W-1:0]};
  assign hold_load   = (state_reg == COLLECT_B) && ENABLE && (count_reg == LAST_BYTE);
  assign hold_accept = (state_reg == HOLD) && OP_READY;

  assign a_nan  = (&op_a_reg[62:52]) && (|op_a_reg[51:0]);
  assign b_nan  = (&b_full[62:52]) && (|b_full[51:0]);
  assign a_inf  = (&op_a_reg[62:52]) && !(|op_a_reg[51:0]);
  assign b_inf  = (&b_full[62:52]) && !(|b_full[51:0]);
  assign a_zero = !(|op_a_reg[62:0]);
  assign b_zero = !(|b_full[62:0]);
  assign sign_z = op_a_reg[63] ^ b_full[63];

  // Special-case classification, first match wins.
  always_comb begin
    special_next   = 1'b0;
    special_z_next = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      special_next   = 1'b1;
      special_z_next = 64'h7FF8_0000_0000_0000;
    end else if (a_inf || b_inf) begin
      special_next   = 1'b1;
      special_z_next = {sign_z, 11'h7FF, 52'h0};
    end else if (a_zero || b_zero) begin
      special_next   = 1'b1;
      special_z_next = {sign_z, 63'h0};
    end
  end

  // Classification result registered alongside OP_VALID, cleared on accept.
  always_ff @(posedge CLK) begin
    if (RESET || hold_accept) begin
      special_reg   <= 1'b0;
      special_z_reg <= '0;
    end else if (hold_load) begin
      special_reg   <= special_next;
      special_z_reg <= special_z_next;
    end
  end

  assign OP_SPECIAL   = special_reg;
  assign OP_SPECIAL_Z = special_z_reg;
`else
  assign OP_SPECIAL   = 1'b0;
  assign OP_SPECIAL_Z = '0;
`endif

endmodule

// File: tb/tb_fp_mul_operand_loader.sv
// Directed bench for fp_mul_operand_loader with an expected-operand scoreboard.
module tb_fp_mul_operand_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic [7:0]  DATA_IN = 8'h00;
  logic        OP_READY = 1'b0;
  logic        BUSY, OP_VALID, OP_SPECIAL, OVERRUN, FRAME_ABORT;
  logic [63:0] OP_A, OP_B, OP_SPECIAL_Z;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        sp;
    logic [63:0] z;
  } exp_t;

  exp_t sb[$];

  fp_mul_operand_loader #(.BYTE_W(8), .WORD_W(64), .IDLE_TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DATA_IN(DATA_IN),
    .BUSY(BUSY), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
    .OP_A(OP_A), .OP_B(OP_B), .OP_SPECIAL(OP_SPECIAL),
    .OP_SPECIAL_Z(OP_SPECIAL_Z), .OVERRUN(OVERRUN), .FRAME_ABORT(FRAME_ABORT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    ENABLE  = 1'b1;
    DATA_IN = b;
    tick();
    ENABLE  = 1'b0;
  endtask

  // Sends bytes [first, last] of the 16-byte frame A,B, LSB first.
  task automatic send_bytes(input logic [63:0] a, input logic [63:0] b,
                            input int first, input int last);
    logic [127:0] frame;
    frame = {b, a};
    for (int i = first; i <= last; i++) send_byte(frame[i*8 +: 8]);
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [63:0] b,
                          input logic sp, input logic [63:0] z);
    exp_t e;
    e.a = a; e.b = b; e.sp = sp; e.z = z;
    sb.push_back(e);
  endtask

  // Waits (bounded) for OP_VALID, then pops the scoreboard and compares.
  task automatic check_out(input string tag);
    exp_t e;
    int   waited;
    waited = 0;
    while (OP_VALID !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    chk({tag, "_valid"}, {63'h0, OP_VALID}, 64'h1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'h0, 64'h1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_a"}, OP_A, e.a);
      chk({tag, "_b"}, OP_B, e.b);
      chk({tag, "_sp"}, {63'h0, OP_SPECIAL}, {63'h0, e.sp});
      chk({tag, "_z"}, OP_SPECIAL_Z, e.z);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {63'h0, OP_VALID}, 64'h0);
    chk({tag, "_busy"}, {63'h0, BUSY}, 64'h0);
    chk({tag, "_a"}, OP_A, 64'h0);
    chk({tag, "_b"}, OP_B, 64'h0);
    chk({tag, "_ovr"}, {63'h0, OVERRUN}, 64'h0);
    chk({tag, "_abort"}, {63'h0, FRAME_ABORT}, 64'h0);
    chk({tag, "_sp"}, {63'h0, OP_SPECIAL}, 64'h0);
    chk({tag, "_z"}, OP_SPECIAL_Z, 64'h0);
  endtask

  localparam logic [63:0] V15 = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] V20 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] INF = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NZ  = 64'h8000_0000_0000_0000;

`ifdef FP_CLASSIFY_EN
  localparam logic CLS = 1'b1;
`else
  localparam logic CLS = 1'b0;
`endif

  initial begin
    logic [63:0] fa, fb, fc, fd;
    fa = 64'h0123_4567_89AB_CDEF;
    fb = 64'hFEDC_BA98_7654_3210;
    fc = 64'h4010_0000_0000_0001;
    fd = 64'hC008_1234_5678_9ABC;

    // Reset state
    tick();
    tick();
    RESET = 1'b0;
    check_all_zero("reset");

    // 1: single frame, core ready; valid exactly one cycle, 1 cycle after byte 16
    OP_READY = 1'b1;
    push_exp(V15, V20, 1'b0, 64'h0);
    send_bytes(V15, V20, 0, 14);
    chk("t1_pre_valid", {63'h0, OP_VALID}, 64'h0);
    send_bytes(V15, V20, 15, 15);
    chk("t1_latency", {63'h0, OP_VALID}, 64'h1);
    check_out("t1");
    tick();
    chk("t1_valid_drop", {63'h0, OP_VALID}, 64'h0);

    // 2: core stalls 5 cycles, byte arrives in HOLD and is dropped
    OP_READY = 1'b0;
    push_exp(fa, fb, 1'b0, 64'h0);
    send_bytes(fa, fb, 0, 15);
    for (int k = 0; k < 4; k++) begin
      chk("t2_hold_valid", {63'h0, OP_VALID}, 64'h1);
      chk("t2_hold_busy", {63'h0, BUSY}, 64'h1);
      chk("t2_hold_a", OP_A, fa);
      tick();
    end
    chk("t2_hold_valid5", {63'h0, OP_VALID}, 64'h1);
    send_byte(8'h5A);
    chk("t2_overrun", {63'h0, OVERRUN}, 64'h1);
    check_out("t2");
    OP_READY = 1'b1;
    tick();
    chk("t2_valid_drop", {63'h0, OP_VALID}, 64'h0);
    chk("t2_ovr_sticky", {63'h0, OVERRUN}, 64'h1);
    tick();
    chk("t2_ovr_sticky2", {63'h0, OVERRUN}, 64'h1);
    do_reset();
    chk("t2_ovr_cleared", {63'h0, OVERRUN}, 64'h0);

    // 3: back-to-back frames, byte 0 of frame 2 on the accept edge
    OP_READY = 1'b1;
    push_exp(fc, fd, 1'b0, 64'h0);
    push_exp(fd, fc, 1'b0, 64'h0);
    send_bytes(fc, fd, 0, 15);
    check_out("t3_f1");
    send_bytes(fd, fc, 0, 15);
    check_out("t3_f2");
    chk("t3_no_overrun", {63'h0, OVERRUN}, 64'h0);
    tick();

    // 4a: 10 bytes then a 4-cycle gap aborts the frame
    send_bytes(fa, fb, 0, 9);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_gap_no_abort", {63'h0, FRAME_ABORT}, 64'h0);
    end
    tick();
    chk("t4_abort_pulse", {63'h0, FRAME_ABORT}, 64'h1);
    chk("t4_abort_novalid", {63'h0, OP_VALID}, 64'h0);
    tick();
    chk("t4_abort_1cycle", {63'h0, FRAME_ABORT}, 64'h0);
    push_exp(fb, fa, 1'b0, 64'h0);
    send_bytes(fb, fa, 0, 15);
    check_out("t4_after_abort");
    tick();

    // 4b: a 3-cycle gap is tolerated
    push_exp(fc, fa, 1'b0, 64'h0);
    send_bytes(fc, fa, 0, 9);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_gap3_no_abort", {63'h0, FRAME_ABORT}, 64'h0);
    end
    send_bytes(fc, fa, 10, 15);
    check_out("t4_gap3");
    tick();

    // 5: special-case classification (all zero when the classifier is absent)
    push_exp(INF, 64'h0, CLS, CLS ? 64'h7FF8_0000_0000_0000 : 64'h0);
    send_bytes(INF, 64'h0, 0, 15);
    check_out("t5_inf_x_zero");
    tick();
    push_exp(64'h0, NZ, CLS, CLS ? 64'h8000_0000_0000_0000 : 64'h0);
    send_bytes(64'h0, NZ, 0, 15);
    check_out("t5_zero_x_nzero");
    tick();
    push_exp(INF, INF, CLS, CLS ? 64'h7FF0_0000_0000_0000 : 64'h0);
    send_bytes(INF, INF, 0, 15);
    check_out("t5_inf_x_inf");
    tick();
    push_exp(V15, V20, 1'b0, 64'h0);
    send_bytes(V15, V20, 0, 15);
    check_out("t5_normal");
    tick();

    // 6: reset after byte 12 discards the frame
    send_bytes(fd, fb, 0, 11);
    do_reset();
    check_all_zero("t6_reset");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_valid", {63'h0, OP_VALID}, 64'h0);
    end
    push_exp(fd, fb, 1'b0, 64'h0);
    send_bytes(fd, fb, 0, 15);
    check_out("t6_fresh");
    tick();
    chk("t6_sb_drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
